lsu_ctrl: RTL and testbench

//  Load/store sequencer for the MEM stage. Takes a memory access from the EX/MEM pipe, runs it on the

---
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer for the MEM stage: issues one access on the data bus with a req/ready + rvalid
// handshake, stalls the pipeline until it completes, and reports misalign, illegal funct3 and bus timeout.
module lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex2mem_mem_read,
    input  logic              ex2mem_mem_write,
    input  logic [2:0]        ex2mem_mem_funct3,
    input  logic [ADDR_W-1:0] ex2mem_alu_out,
    input  logic [31:0]       ex2mem_rs2_data,
    input  logic              flush,
    output logic              dbus_req,
    output logic              dbus_write,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [31:0]       dbus_wdata,
    output logic [3:0]        dbus_byteen,
    input  logic              dbus_ready,
    input  logic              dbus_rvalid,
    input  logic [31:0]       dbus_rdata,
    output logic              lsu_stall,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_rdata_valid,
    output logic              lsu_misalign,
    output logic              lsu_ill_funct3,
    output logic              lsu_bus_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [2:0]        r_funct3;
    logic [3:0]        r_byteen;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_rdata_valid;
    logic              r_bus_err;

    logic              w_access;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_go;
    logic [3:0]        w_byteen;
    logic [31:0]       w_wdata;

    // Offset is only ever nonzero for sub-word accesses, so the shifted word is exact for LW too.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] ofs,
                                             input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {ofs, 3'b000};
        case (f3)
            3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
            3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
            3'b100:  fmt_load = {24'd0, sh[7:0]};
            3'b101:  fmt_load = {16'd0, sh[15:0]};
            default: fmt_load = sh;
        endcase
    endfunction

    assign w_access = (ex2mem_mem_read | ex2mem_mem_write) & ~flush;

    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        w_byteen   = 4'b1111;
        w_wdata    = ex2mem_rs2_data;
        if (ex2mem_mem_read) begin
            w_illegal = (ex2mem_mem_funct3 == 3'b011) | (ex2mem_mem_funct3[2:1] == 2'b11);
        end else begin
            w_illegal = (ex2mem_mem_funct3 == 3'b011) | ex2mem_mem_funct3[2];
        end
        case (ex2mem_mem_funct3[1:0])
            2'b00: begin
                w_byteen = 4'b0001 << ex2mem_alu_out[1:0];
                w_wdata  = {4{ex2mem_rs2_data[7:0]}};
            end
            2'b01: begin
                w_misalign = ex2mem_alu_out[0];
                w_byteen   = 4'b0011 << ex2mem_alu_out[1:0];
                w_wdata    = {2{ex2mem_rs2_data[15:0]}};
            end
            default: w_misalign = (ex2mem_alu_out[1:0] != 2'b00);
        endcase
    end

    assign w_go           = (r_state == ST_IDLE) & w_access & ~w_illegal & ~w_misalign;
    assign lsu_ill_funct3 = (r_state == ST_IDLE) & w_access & w_illegal;
    assign lsu_misalign   = (r_state == ST_IDLE) & w_access & ~w_illegal & w_misalign;
    assign lsu_stall      = w_go | (r_state == ST_REQ) | (r_state == ST_RESP);

    assign dbus_req        = (r_state == ST_REQ);
    assign dbus_write      = r_write;
    assign dbus_addr       = r_addr;
    assign dbus_wdata      = r_wdata;
    assign dbus_byteen     = r_byteen;
    assign lsu_rdata       = r_rdata;
    assign lsu_rdata_valid = r_rdata_valid;
    assign lsu_bus_err     = r_bus_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_funct3      <= 3'b000;
            r_byteen      <= 4'b0000;
            r_wdata       <= 32'd0;
            r_rdata       <= 32'd0;
            r_rdata_valid <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_bus_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_addr   <= ex2mem_alu_out;
                        r_write  <= ex2mem_mem_write;
                        r_funct3 <= ex2mem_mem_funct3;
                        r_byteen <= w_byteen;
                        r_wdata  <= w_wdata;
                        r_cnt    <= '0;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dbus_ready) begin
                        r_cnt   <= '0;
                        r_state <= r_write ? ST_DONE : ST_RESP;
                    end else if (r_cnt == CNT_MAX) begin
                        r_bus_err <= 1'b1;
                        r_rdata   <= 32'd0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (dbus_rvalid) begin
                        r_rdata       <= fmt_load(r_funct3, r_addr[1:0], dbus_rdata);
                        r_rdata_valid <= 1'b1;
                        r_state       <= ST_DONE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_bus_err <= 1'b1;
                        r_rdata   <= 32'd0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stores, loads of every width, error pulses, timeout and reset mid-access.
module tb_lsu_ctrl;

    localparam int ADDR_W = 32;
    localparam int TO     = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex2mem_mem_read;
    logic              ex2mem_mem_write;
    logic [2:0]        ex2mem_mem_funct3;
    logic [ADDR_W-1:0] ex2mem_alu_out;
    logic [31:0]       ex2mem_rs2_data;
    logic              flush;
    logic              dbus_req;
    logic              dbus_write;
    logic [ADDR_W-1:0] dbus_addr;
    logic [31:0]       dbus_wdata;
    logic [3:0]        dbus_byteen;
    logic              dbus_ready;
    logic              dbus_rvalid;
    logic [31:0]       dbus_rdata;
    logic              lsu_stall;
    logic [31:0]       lsu_rdata;
    logic              lsu_rdata_valid;
    logic              lsu_misalign;
    logic              lsu_ill_funct3;
    logic              lsu_bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .ex2mem_mem_read(ex2mem_mem_read), .ex2mem_mem_write(ex2mem_mem_write),
        .ex2mem_mem_funct3(ex2mem_mem_funct3), .ex2mem_alu_out(ex2mem_alu_out),
        .ex2mem_rs2_data(ex2mem_rs2_data), .flush(flush),
        .dbus_req(dbus_req), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_byteen(dbus_byteen), .dbus_ready(dbus_ready),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .lsu_stall(lsu_stall), .lsu_rdata(lsu_rdata), .lsu_rdata_valid(lsu_rdata_valid),
        .lsu_misalign(lsu_misalign), .lsu_ill_funct3(lsu_ill_funct3), .lsu_bus_err(lsu_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        ex2mem_mem_read   = rd;
        ex2mem_mem_write  = wr;
        ex2mem_mem_funct3 = f3;
        ex2mem_alu_out    = a;
        ex2mem_rs2_data   = d;
        #1;
    endtask

    task automatic clear();
        ex2mem_mem_read  = 1'b0;
        ex2mem_mem_write = 1'b0;
        flush            = 1'b0;
        dbus_ready       = 1'b0;
        dbus_rvalid      = 1'b0;
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be, input logic [31:0] wd,
                             input int nwait);
        present(1'b0, 1'b1, f3, a, d);
        chk({tag, " stall idle"}, 32'(lsu_stall), 32'd1);
        tick();
        for (int i = 0; i <= nwait; i++) begin
            chk({tag, " req"}, 32'(dbus_req), 32'd1);
            chk({tag, " write"}, 32'(dbus_write), 32'd1);
            chk({tag, " addr"}, dbus_addr, a);
            chk({tag, " byteen"}, 32'(dbus_byteen), 32'(be));
            chk({tag, " wdata"}, dbus_wdata, wd);
            chk({tag, " stall req"}, 32'(lsu_stall), 32'd1);
            if (i == nwait) dbus_ready = 1'b1;
            tick();
        end
        dbus_ready = 1'b0;
        chk({tag, " done req"}, 32'(dbus_req), 32'd0);
        chk({tag, " done stall"}, 32'(lsu_stall), 32'd0);
        chk({tag, " done valid"}, 32'(lsu_rdata_valid), 32'd0);
        chk({tag, " done err"}, 32'(lsu_bus_err), 32'd0);
        clear();
        tick();
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
        present(1'b1, 1'b0, f3, a, 32'd0);
        chk({tag, " stall idle"}, 32'(lsu_stall), 32'd1);
        tick();
        chk({tag, " req"}, 32'(dbus_req), 32'd1);
        chk({tag, " write"}, 32'(dbus_write), 32'd0);
        chk({tag, " byteen"}, 32'(dbus_byteen), 32'(be));
        dbus_ready = 1'b1;
        tick();
        dbus_ready = 1'b0;
        chk({tag, " resp req"}, 32'(dbus_req), 32'd0);
        chk({tag, " resp stall"}, 32'(lsu_stall), 32'd1);
        dbus_rvalid = 1'b1;
        dbus_rdata  = rd;
        tick();
        dbus_rvalid = 1'b0;
        chk({tag, " rdata"}, lsu_rdata, exp);
        chk({tag, " valid"}, 32'(lsu_rdata_valid), 32'd1);
        chk({tag, " done stall"}, 32'(lsu_stall), 32'd0);
        chk({tag, " done err"}, 32'(lsu_bus_err), 32'd0);
        clear();
        tick();
        chk({tag, " valid pulse"}, 32'(lsu_rdata_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ex2mem_mem_funct3 = 3'b000;
        ex2mem_alu_out    = '0;
        ex2mem_rs2_data   = 32'd0;
        dbus_rdata        = 32'd0;
        clear();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst req", 32'(dbus_req), 32'd0);
        chk("rst write", 32'(dbus_write), 32'd0);
        chk("rst addr", dbus_addr, 32'd0);
        chk("rst wdata", dbus_wdata, 32'd0);
        chk("rst byteen", 32'(dbus_byteen), 32'd0);
        chk("rst rdata", lsu_rdata, 32'd0);
        chk("rst valid", 32'(lsu_rdata_valid), 32'd0);
        chk("rst err", 32'(lsu_bus_err), 32'd0);
        chk("rst stall", 32'(lsu_stall), 32'd0);

        run_store("SW", 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0);
        run_store("SH wait3", 3'b001, 32'h102, 32'h00001234, 4'b1100, 32'h12341234, 3);
        run_store("SB", 3'b000, 32'h101, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 0);

        run_load("LB", 3'b000, 32'h103, 32'h80123456, 4'b1000, 32'hFFFFFF80);
        run_load("LBU", 3'b100, 32'h103, 32'h80123456, 4'b1000, 32'h00000080);
        run_load("LH", 3'b001, 32'h102, 32'h80017777, 4'b1100, 32'hFFFF8001);
        run_load("LHU", 3'b101, 32'h100, 32'h1234F00D, 4'b0011, 32'h0000F00D);
        run_load("LW", 3'b010, 32'h104, 32'h12345678, 4'b1111, 32'h12345678);

        present(1'b1, 1'b0, 3'b001, 32'h101, 32'd0);
        chk("LH mis pulse", 32'(lsu_misalign), 32'd1);
        chk("LH mis ill", 32'(lsu_ill_funct3), 32'd0);
        chk("LH mis stall", 32'(lsu_stall), 32'd0);
        tick();
        chk("LH mis noreq", 32'(dbus_req), 32'd0);
        clear();

        present(1'b1, 1'b0, 3'b011, 32'h100, 32'd0);
        chk("ld011 ill", 32'(lsu_ill_funct3), 32'd1);
        chk("ld011 stall", 32'(lsu_stall), 32'd0);
        tick();
        chk("ld011 noreq", 32'(dbus_req), 32'd0);
        present(1'b1, 1'b0, 3'b110, 32'h101, 32'd0);
        chk("ld110 ill", 32'(lsu_ill_funct3), 32'd1);
        chk("ld110 mis prio", 32'(lsu_misalign), 32'd0);
        present(1'b0, 1'b1, 3'b100, 32'h100, 32'd0);
        chk("st100 ill", 32'(lsu_ill_funct3), 32'd1);
        clear();
        tick();

        flush = 1'b1;
        present(1'b0, 1'b1, 3'b010, 32'h100, 32'h11111111);
        chk("flush stall", 32'(lsu_stall), 32'd0);
        tick();
        chk("flush noreq", 32'(dbus_req), 32'd0);
        clear();
        tick();

        present(1'b1, 1'b0, 3'b010, 32'h200, 32'd0);
        tick();
        for (int i = 0; i < TO; i++) begin
            chk("to req held", 32'(dbus_req), 32'd1);
            tick();
        end
        chk("to err", 32'(lsu_bus_err), 32'd1);
        chk("to valid", 32'(lsu_rdata_valid), 32'd0);
        chk("to rdata", lsu_rdata, 32'd0);
        chk("to req drop", 32'(dbus_req), 32'd0);
        clear();
        tick();
        chk("to err pulse", 32'(lsu_bus_err), 32'd0);
        chk("to idle stall", 32'(lsu_stall), 32'd0);

        present(1'b1, 1'b0, 3'b010, 32'h300, 32'd0);
        tick();
        dbus_ready = 1'b1;
        tick();
        dbus_ready = 1'b0;
        chk("rst-resp stall", 32'(lsu_stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear();
        #1;
        chk("rst-resp req", 32'(dbus_req), 32'd0);
        chk("rst-resp stall0", 32'(lsu_stall), 32'd0);
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hCAFEF00D;
        tick();
        dbus_rvalid = 1'b0;
        chk("rst-resp novalid", 32'(lsu_rdata_valid), 32'd0);
        chk("rst-resp rdata", lsu_rdata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
